// File: rtl/pipeline_uart_pkg.sv
// Shared definitions for the pipeline CPU UART baud generator: minimum divisor,
// reset-time divisor computation and the divisor container.
package pipeline_uart_pkg;

  localparam int DIV_MIN = 2;

  // Wide enough for any practical DIV_W/FRAC_W; users truncate to their widths.
  typedef struct packed {
    logic [31:0] ipart;
    logic [15:0] fpart;
  } uart_div_t;

  // Rounded sample period in 1/2^frac_w cycle units, split into int/frac.
  function automatic uart_div_t d0_split(longint clk_hz, longint baud,
                                         longint os, int frac_w);
    uart_div_t r;
    longint den;
    longint d0;
    den = baud * os;
    d0 = ((clk_hz <<< frac_w) + den / 2) / den;
    r.ipart = 32'(d0 >>> frac_w);
    r.fpart = 16'(d0 & ((longint'(1) <<< frac_w) - 1));
    return r;
  endfunction

endpackage

// File: rtl/pipeline_uart_frac_div.sv
// Fractional down-counter: owns the cycle counter and fractional accumulator,
// flags the cycle a sample tick is due and every reload event.
module pipeline_uart_frac_div
  import pipeline_uart_pkg::*;
#(
  parameter int               DIV_W   = 16,
  parameter int               FRAC_W  = 4,
  parameter logic [DIV_W-1:0] RST_CNT = '0
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic              enable,
  input  logic              phase_sync,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  output logic              tick,
  output logic              reload
);

  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

  logic [DIV_W-1:0]  cnt;
  logic [FRAC_W-1:0] acc;
  logic [FRAC_W:0]   sum;
  logic              due;

  assign sum    = {1'b0, acc} + {1'b0, div_frac};
  assign due    = (cnt == '0);
  assign tick   = enable && due && !phase_sync;
  assign reload = enable && (due || phase_sync);

  // div_int is already clamped to >= 2, so period-1 never underflows and
  // div_int-1+carry never overflows DIV_W bits.
  always_ff @(posedge sysclk) begin
    if (!reset) begin
      cnt <= RST_CNT;
      acc <= '0;
    end else if (enable) begin
      if (phase_sync) begin
        cnt <= div_int - ONE;
        acc <= '0;
      end else if (due) begin
        cnt <= div_int - ONE + DIV_W'(sum[FRAC_W]);
        acc <= sum[FRAC_W-1:0];
      end else begin
        cnt <= cnt - ONE;
      end
    end
  end

endmodule

// File: rtl/pipeline_uart_baudgen.sv
// UART baud generator: oversample tick, mid-bit tick and legacy sampleclk, with a
// runtime-reprogrammable fractional divisor and RX phase realignment.
module pipeline_uart_baudgen
  import pipeline_uart_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16,
  parameter int FRAC_W     = 4
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic              enable,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [DIV_W-1:0]  cfg_div_int,
  input  logic [FRAC_W-1:0] cfg_div_frac,
  input  logic              phase_sync,
  output logic              sample_tick,
  output logic              bit_tick,
  output logic              sampleclk
);

  localparam int SUB_W = $clog2(OVERSAMPLE);
  localparam uart_div_t D0 = d0_split(CLK_HZ, BAUD, OVERSAMPLE, FRAC_W);
  localparam logic [DIV_W-1:0] D0_INT =
    (D0.ipart < 32'(DIV_MIN)) ? DIV_W'(DIV_MIN) : DIV_W'(D0.ipart);
  localparam logic [FRAC_W-1:0] D0_FRAC  = FRAC_W'(D0.fpart);
  localparam logic [SUB_W-1:0]  SUB_LAST = SUB_W'(OVERSAMPLE - 1);
  localparam logic [SUB_W-1:0]  SUB_HALF = SUB_W'(OVERSAMPLE / 2);

  logic [DIV_W-1:0]  act_int, shd_int, eff_raw, eff_int;
  logic [FRAC_W-1:0] act_frac, shd_frac, eff_frac;
  logic              pending;
  logic [SUB_W-1:0]  sub;
  logic              tick, reload;

  // A pending shadow takes effect on the very reload that consumes it.
  assign eff_raw  = pending ? shd_int : act_int;
  assign eff_int  = (eff_raw < DIV_W'(DIV_MIN)) ? DIV_W'(DIV_MIN) : eff_raw;
  assign eff_frac = pending ? shd_frac : act_frac;
  assign cfg_ready = !pending;

  pipeline_uart_frac_div #(
    .DIV_W   (DIV_W),
    .FRAC_W  (FRAC_W),
    .RST_CNT (D0_INT - DIV_W'(1))
  ) u_div (
    .sysclk     (sysclk),
    .reset      (reset),
    .enable     (enable),
    .phase_sync (phase_sync),
    .div_int    (eff_int),
    .div_frac   (eff_frac),
    .tick       (tick),
    .reload     (reload)
  );

  always_ff @(posedge sysclk) begin
    if (!reset) begin
      act_int     <= D0_INT;
      act_frac    <= D0_FRAC;
      shd_int     <= '0;
      shd_frac    <= '0;
      pending     <= 1'b0;
      sub         <= '0;
      sample_tick <= 1'b0;
      bit_tick    <= 1'b0;
      sampleclk   <= 1'b1;
    end else begin
      sample_tick <= tick;
      bit_tick    <= tick && (sub == SUB_LAST);
      if (tick) begin
        sampleclk <= ~sampleclk;
        sub       <= (sub == SUB_LAST) ? '0 : sub + SUB_W'(1);
      end else if (enable && phase_sync) begin
        sub <= SUB_HALF;
      end
      if (reload) begin
        act_int  <= eff_int;
        act_frac <= eff_frac;
        pending  <= 1'b0;
      end
      // Transfer needs !pending, so it never collides with consuming a shadow;
      // one landing on a reload edge waits for the following reload.
      if (cfg_valid && !pending) begin
        shd_int  <= cfg_div_int;
        shd_frac <= cfg_div_frac;
        pending  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_uart_baudgen.sv
// Bench for pipeline_uart_baudgen: timestamp-based reference model plus directed
// scenarios with hand-computed tick spacings.
module tb_pipeline_uart_baudgen;

  localparam int CLK_HZ = 100_000_000;
  localparam int BAUD   = 9600;
  localparam int OS     = 16;
  localparam int DIV_W  = 16;
  localparam int FRAC_W = 4;
  localparam int F1     = 1 << FRAC_W;
  localparam longint DEN = longint'(BAUD) * OS;
  localparam longint D0  = (longint'(CLK_HZ) * F1 + DEN / 2) / DEN;
  localparam int D0_I = int'(D0 / F1);
  localparam int D0_F = int'(D0 % F1);

  logic              sysclk = 1'b0;
  logic              reset = 1'b0;
  logic              enable = 1'b0;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready;
  logic [DIV_W-1:0]  cfg_div_int = '0;
  logic [FRAC_W-1:0] cfg_div_frac = '0;
  logic              phase_sync = 1'b0;
  logic              sample_tick, bit_tick, sampleclk;

  pipeline_uart_baudgen #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS), .DIV_W(DIV_W), .FRAC_W(FRAC_W)
  ) dut (
    .sysclk(sysclk), .reset(reset), .enable(enable), .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready), .cfg_div_int(cfg_div_int), .cfg_div_frac(cfg_div_frac),
    .phase_sync(phase_sync), .sample_tick(sample_tick), .bit_tick(bit_tick),
    .sampleclk(sampleclk)
  );

  always #5 sysclk = ~sysclk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  bit chk_en = 1'b0;
  int tstamp[$];
  int bstamp[$];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int clampi(input int v);
    return (v < 2) ? 2 : v;
  endfunction

  // Reference model: ticks are scheduled as absolute counts of enabled edges.
  int m_edges = 0, m_due = 0, m_acc = 0, m_int = 0, m_frac = 0;
  int m_shd_int = 0, m_shd_frac = 0, m_nticks = 0, m_off = 0;
  bit m_pend = 1'b0, m_tick = 1'b0, m_bit = 1'b0;

  always @(posedge sysclk) begin : model
    bit pend_old, rl;
    int ei, ef, s;
    if (!reset) begin
      m_edges = 0; m_int = clampi(D0_I); m_frac = D0_F; m_acc = 0;
      m_due = m_int; m_pend = 1'b0; m_nticks = 0; m_off = 0;
      m_tick = 1'b0; m_bit = 1'b0;
    end else begin
      pend_old = m_pend; rl = 1'b0; m_tick = 1'b0; m_bit = 1'b0;
      ei = clampi(m_pend ? m_shd_int : m_int);
      ef = m_pend ? m_shd_frac : m_frac;
      if (enable) begin
        m_edges++;
        if (phase_sync) begin
          rl = 1'b1; m_acc = 0; m_due = m_edges + ei;
          m_off = ((OS / 2) - (m_nticks % OS) + OS) % OS;
        end else if (m_edges == m_due) begin
          rl = 1'b1; m_tick = 1'b1;
          m_bit = ((m_nticks + m_off) % OS) == OS - 1;
          m_nticks++;
          s = m_acc + ef;
          m_due = m_edges + ei + s / F1;
          m_acc = s % F1;
        end
      end
      if (rl) begin m_int = ei; m_frac = ef; m_pend = 1'b0; end
      if (cfg_valid && !pend_old) begin
        m_shd_int = int'(cfg_div_int); m_shd_frac = int'(cfg_div_frac); m_pend = 1'b1;
      end
    end
  end

  always @(negedge sysclk) begin
    cyc++;
    if (sample_tick) tstamp.push_back(cyc);
    if (bit_tick) bstamp.push_back(cyc);
    if (chk_en) begin
      chk("sample_tick", int'(sample_tick), int'(m_tick));
      chk("bit_tick", int'(bit_tick), int'(m_bit));
      chk("sampleclk", int'(sampleclk), (m_nticks % 2 == 0) ? 1 : 0);
      chk("cfg_ready", int'(cfg_ready), m_pend ? 0 : 1);
    end
  end

  task automatic step();
    @(negedge sysclk);
    #1;
  endtask

  task automatic wait_ntick(input int n, input int budget);
    int target;
    int k;
    target = tstamp.size() + n;
    k = 0;
    while (tstamp.size() < target && k < budget) begin
      step();
      k++;
    end
    chk("tick_timeout", (tstamp.size() >= target) ? 1 : 0, 1);
  endtask

  initial begin : stim
    int c0, n0, nb, t0, g1, g2, g3, g4, k;
    // Reset state
    step(); chk_en = 1'b1;
    step(); step();
    chk("rst_sample_tick", int'(sample_tick), 0);
    chk("rst_bit_tick", int'(bit_tick), 0);
    chk("rst_sampleclk", int'(sampleclk), 1);
    chk("rst_cfg_ready", int'(cfg_ready), 1);

    // Defaults: 651 + 1/16
    reset = 1'b1; enable = 1'b1; c0 = cyc;
    wait_ntick(17, 12000);
    chk("first_tick_latency", tstamp[0] - c0, 651);
    chk("gap_2", tstamp[1] - tstamp[0], 651);
    chk("gap_17_long", tstamp[16] - tstamp[15], 652);
    chk("bit_tick_count", bstamp.size(), 1);
    chk("bit_tick_on_16th", bstamp[0], tstamp[15]);
    chk("sampleclk_after_17", int'(sampleclk), 0);

    // 4 + 8/16 alternates 4,5
    step(); cfg_valid = 1'b1; cfg_div_int = 16'd4; cfg_div_frac = 4'd8;
    step(); cfg_valid = 1'b0;
    chk("ready_low_after_xfer", int'(cfg_ready), 0);
    wait_ntick(1, 1000);
    chk("ready_high_after_reload", int'(cfg_ready), 1);
    n0 = tstamp.size();
    wait_ntick(4, 50);
    g1 = tstamp[n0] - tstamp[n0-1]; g2 = tstamp[n0+1] - tstamp[n0];
    g3 = tstamp[n0+2] - tstamp[n0+1]; g4 = tstamp[n0+3] - tstamp[n0+2];
    chk("frac_gap_range", (g1 == 4 || g1 == 5) ? 1 : 0, 1);
    chk("frac_pair_1", g1 + g2, 9);
    chk("frac_pair_2", g2 + g3, 9);
    chk("frac_pair_3", g3 + g4, 9);

    // div_int 0 clamps to 2; second offer held off while pending
    step(); cfg_valid = 1'b1; cfg_div_int = 16'd0; cfg_div_frac = 4'd0;
    step(); cfg_div_int = 16'd3;
    chk("ready_held_off", int'(cfg_ready), 0);
    k = 0;
    while (!cfg_ready && k < 20) begin step(); k++; end
    chk("ready_rise", int'(cfg_ready), 1);
    n0 = tstamp.size();
    step(); cfg_valid = 1'b0;
    wait_ntick(2, 50);
    chk("clamped_gap", tstamp[n0] - tstamp[n0-1], 2);
    chk("second_cfg_gap", tstamp[n0+1] - tstamp[n0], 3);

    // phase_sync on a tick-due cycle with period 4
    step(); cfg_valid = 1'b1; cfg_div_int = 16'd4;
    step(); cfg_valid = 1'b0;
    wait_ntick(1, 50);
    wait_ntick(1, 50);
    t0 = tstamp[tstamp.size()-1];
    n0 = tstamp.size();
    step(); step(); step(); phase_sync = 1'b1;
    step(); phase_sync = 1'b0;
    chk("sync_suppresses_tick", tstamp.size(), n0);
    nb = bstamp.size();
    wait_ntick(8, 100);
    chk("sync_next_tick", tstamp[n0] - t0, 8);
    chk("sync_bit_count", bstamp.size() - nb, 1);
    chk("sync_bit_on_8th", bstamp[bstamp.size()-1], tstamp[n0+7]);

    // enable low for 10 cycles; config accepted while frozen
    wait_ntick(1, 50);
    t0 = tstamp[tstamp.size()-1];
    n0 = tstamp.size();
    step(); enable = 1'b0;
    step(); step(); cfg_valid = 1'b1; cfg_div_int = 16'd6;
    step(); cfg_valid = 1'b0;
    step();
    chk("ready_low_frozen", int'(cfg_ready), 0);
    repeat (6) step();
    chk("frozen_no_ticks", tstamp.size(), n0);
    enable = 1'b1;
    wait_ntick(2, 50);
    chk("resume_gap", tstamp[n0] - t0, 14);
    chk("frozen_cfg_applied", tstamp[n0+1] - tstamp[n0], 6);

    // reset mid-operation with a pending config
    step(); cfg_valid = 1'b1; cfg_div_int = 16'd9;
    step(); cfg_valid = 1'b0; reset = 1'b0;
    step();
    chk("midrst_sample_tick", int'(sample_tick), 0);
    chk("midrst_bit_tick", int'(bit_tick), 0);
    chk("midrst_sampleclk", int'(sampleclk), 1);
    chk("midrst_cfg_ready", int'(cfg_ready), 1);
    reset = 1'b1; c0 = cyc;
    wait_ntick(1, 1000);
    chk("midrst_d0_restored", tstamp[tstamp.size()-1] - c0, 651);

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_uart_baudgen.md
# pipeline_uart_baudgen

Parametrised UART baud-rate generator for the pipeline CPU's UART. From `sysclk` it produces a one-cycle oversample tick, a one-cycle mid-bit tick, and a legacy `sampleclk` square wave. The divisor is fractional and reprogrammable at runtime through a valid/ready handshake. A phase-sync input lets the receiver realign bit timing on a start edge. It sits between the system clock and the UART TX/RX shift logic.

## Interface
- `CLK_HZ`, 100_000_000: `sysclk` frequency.
- `BAUD`, 9600: reset-time baud rate.
- `OVERSAMPLE`, 16: sample ticks per bit; must be even and ≥4.
- `DIV_W`, 16: width of the integer divisor.
- `FRAC_W`, 4: width of the fractional divisor, in units of 1/2^FRAC_W cycle.
- `sysclk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-low.
- `enable` in 1: run when high; freeze when low.
- `cfg_valid` in 1: new divisor offered.
- `cfg_ready` out 1: shadow register free.
- `cfg_div_int` in DIV_W: integer part of the sample period, in cycles.
- `cfg_div_frac` in FRAC_W: fractional part of the sample period.
- `phase_sync` in 1: realign to mid-bit (RX start edge).
- `sample_tick` out 1: one-cycle pulse at BAUD×OVERSAMPLE.
- `bit_tick` out 1: one-cycle pulse once per OVERSAMPLE sample ticks.
- `sampleclk` out 1: toggles on every `sample_tick`.

## Operation
- Default divisor D0 = round(CLK_HZ·2^FRAC_W / (BAUD·OVERSAMPLE)), split into int/frac parts. Defaults give 651 + 1/16.
- Active divisor values with `div_int` < 2 are clamped to 2.
- Sample period: each reload computes `acc + div_frac` in FRAC_W+1 bits.
  - Carry out c sets the period to `div_int + c` cycles.
  - `acc` takes the low FRAC_W bits of the sum.
- Down-counter `cnt`: when `cnt == 0` and `enable`, assert `sample_tick`, then reload with period−1.
- Sub-counter `sub` runs 0..OVERSAMPLE−1 and increments on each `sample_tick`.
  - `bit_tick` asserts with the `sample_tick` on which `sub == OVERSAMPLE−1`; `sub` then wraps to 0.
- Config handshake:
  - Transfer occurs when `cfg_valid && cfg_ready`; the divisor goes into a shadow register with a pending flag.
  - `cfg_ready` = !pending.
  - Pending shadow is copied to the active divisor at the next reload (tick or `phase_sync`), then pending clears.
  - A transfer in the same cycle as a reload applies at the following reload.
- `phase_sync` (only while `enable` is high):
  - `cnt` reloads with the full period; `acc` clears; `sub` is set to OVERSAMPLE/2.
  - Any pending shadow is applied.
  - Next `bit_tick` comes OVERSAMPLE/2 sample ticks later.
- `phase_sync` and a tick-due cycle together: `phase_sync` wins and no `sample_tick`/`bit_tick` is emitted that cycle.
- `enable` low: `cnt`, `sub`, `acc` and `sampleclk` hold; no ticks. Handshake still accepts, pending persists.
- Reset values (reset low at a `sysclk` edge):
  - Active divisor = D0, `cnt` = D0 period−1, `sub` = 0, `acc` = 0, pending = 0.
  - Outputs: `sample_tick` = 0, `bit_tick` = 0, `sampleclk` = 1, `cfg_ready` = 1.
  - Reset mid-operation aborts any pending config.

## Timing
- All outputs are registered; ticks last exactly one cycle.
- First `sample_tick` comes `div_int` cycles after the first enabled cycle following reset release. With frac 0, spacing is exactly `div_int` cycles.
- `cfg_ready` falls in the cycle after a transfer and rises in the cycle after the reload that consumes the shadow.
- `sampleclk` changes in the same cycle as `sample_tick`; its period is 2 sample periods.

## Structure
- Package `pipeline_uart_pkg` holds:
  - `DIV_MIN = 2`;
  - the D0 rounding function;
  - the divisor struct {int, frac}.
- One sub-module, `pipeline_uart_frac_div`: owns `cnt` and `acc`, emits the raw tick. The top level owns `sub`, the shadow/handshake, and `sampleclk`.

## Test plan
- Reset then enable with defaults → first `sample_tick` after 651 cycles; one in every 16 periods is 652 cycles; `bit_tick` every 16th tick; `sampleclk` starts at 1 and toggles on each tick.
- Load `div_int` = 4, `div_frac` = 8 → periods alternate 4, 5, 4, 5; `cfg_ready` low from transfer until the next reload.
- Load `div_int` = 0 → runs with period 2; a second `cfg_valid` while pending is held off (`cfg_ready` = 0) until the reload.
- With `div_int` = 4, pulse `phase_sync` in a tick-due cycle → no tick that cycle; next tick after 4 cycles; `bit_tick` on the 8th subsequent `sample_tick`.
- Drop `enable` for 10 cycles mid-period → no ticks; count resumes from the frozen value (total gap = period + 10).
- Assert `reset` low mid-operation with a config pending → all outputs at reset values next cycle, pending cleared, D0 restored.
